// File: rtl/addsub_sequencer.sv
// Command sequencer and accumulator that drives an external combinational
// add/sub unit. Commands arrive on a valid/ready handshake and results leave on another.
module addsub_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CNT_W-1:0] in_cnt,
   output logic [WIDTH-1:0] au_a,
   output logic [WIDTH-1:0] au_b,
   output logic             au_sel,
   input  logic [WIDTH-1:0] au_s,
   input  logic             au_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_acc,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_v_any,
   output logic             flag_z,
   output logic             flag_n
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

   logic [1:0]       state_r;
   logic [WIDTH-1:0] acc_r;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] data_r;
   logic             sel_r;
   logic [CNT_W-1:0] remaining_r;
   logic             flag_c_r;
   logic             flag_v_r;
   logic             flag_v_any_r;
   logic             ovf_s;

   // Signed overflow: operands of equal sign (after sub inversion) give a result of the other sign.
   function automatic logic ovf_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic sel, input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] b_eff;
      b_eff = b ^ {WIDTH{sel}};
      return (a[WIDTH-1] == b_eff[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
   endfunction

   assign ovf_s = ovf_f(acc_r, data_r, sel_r, au_s);

   // sel has its own register so the unit never sees a decode glitch.
   assign au_a       = acc_r;
   assign au_b       = data_r;
   assign au_sel     = sel_r;
   assign in_ready   = (state_r == ST_IDLE);
   assign out_valid  = (state_r == ST_DONE);
   assign out_acc    = acc_r;
   assign flag_c     = flag_c_r;
   assign flag_v     = flag_v_r;
   assign flag_v_any = flag_v_any_r;
   assign flag_z     = (acc_r == {WIDTH{1'b0}});
   assign flag_n     = acc_r[WIDTH-1];

   // Sequencer state, accumulator and flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         acc_r        <= {WIDTH{1'b0}};
         op_r         <= OP_LOAD;
         data_r       <= {WIDTH{1'b0}};
         sel_r        <= 1'b0;
         remaining_r  <= {CNT_W{1'b0}};
         flag_c_r     <= 1'b0;
         flag_v_r     <= 1'b0;
         flag_v_any_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  op_r   <= in_op;
                  data_r <= in_data;
                  sel_r  <= (in_op == OP_SUB);
                  case (in_op)
                     OP_LOAD: begin
                        acc_r        <= in_data;
                        flag_c_r     <= 1'b0;
                        flag_v_r     <= 1'b0;
                        flag_v_any_r <= 1'b0;
                        state_r      <= ST_DONE;
                     end
                     OP_CLR: begin
                        acc_r        <= {WIDTH{1'b0}};
                        flag_c_r     <= 1'b0;
                        flag_v_r     <= 1'b0;
                        flag_v_any_r <= 1'b0;
                        state_r      <= ST_DONE;
                     end
                     default: begin
                        flag_v_any_r <= 1'b0;
                        remaining_r  <= in_cnt;
                        state_r      <= ST_EXEC;
                     end
                  endcase
               end
            end
            ST_EXEC: begin
               acc_r        <= au_s;
               flag_c_r     <= au_cout;
               flag_v_r     <= ovf_s;
               flag_v_any_r <= flag_v_any_r | ovf_s;
               if (remaining_r == {CNT_W{1'b0}}) begin
                  state_r <= ST_DONE;
               end else begin
                  remaining_r <= remaining_r - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
